// File: rtl/dff_mem_ctrl.sv
// -----------------------------------------------------------------------------
// dff_mem_ctrl
//
// Byte-addressable working RAM for the SAP-style datapath, built from flops.
// Adds three things to the plain 16x8 DFF memory:
//   * a self-clearing sweep that zeroes every location after reset or on
//     request (busy is high while it runs),
//   * a registered read-valid strobe alongside the registered read data,
//   * an auto-incrementing program-load port for filling memory from the host.
//
// Optional feature macro: DFF_MEM_PARITY_EN
//   When defined, each location carries an even-parity bit; par_inj inverts it
//   on a write, and parity_err reports a mismatch together with rd_valid.
//   When undefined, par_inj is ignored and parity_err is constant 0.
//
// Parameters:
//   DATA_W    data word width (default 8)
//   ADDR_W    address width, depth = 2**ADDR_W (default 4)
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             design enable; all state holds while low
//   mar             CPU bus address
//   data_in         write data for CPU and program loads
//   data_out        registered read data
//   ce_n, lr_n      active-low read and write strobes
//   rd_valid        one-cycle pulse when data_out was refreshed by a read
//   clr_req         request a full clear sweep
//   prog_en         level, selects program-load mode
//   prog_wr         program-load write strobe
//   prog_addr       next program-load address
//   prog_full       last location written in this program session
//   busy            clear sweep in progress
//   par_inj         invert stored parity on this write (test hook)
//   parity_err      parity mismatch on the read flagged by rd_valid
// -----------------------------------------------------------------------------
module dff_mem_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [ADDR_W-1:0] mar,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              ce_n,
    input  logic              lr_n,
    output logic              rd_valid,
    input  logic              clr_req,
    input  logic              prog_en,
    input  logic              prog_wr,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              prog_full,
    output logic              busy,
    input  logic              par_inj,
    output logic              parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef DFF_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        PROG  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_ptr;

    logic [WORD_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] wr_data;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] rd_word;
    logic              rd_en;
    logic              clr_start;
    logic              prog_start;
    logic              prog_step;

    // -------------------------------------------------------------------------
    // Next-state and per-cycle access decode. Everything is qualified by ena,
    // so a disabled cycle produces no write, no read and no transition.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block from inferring latches.
        state_next = state;
        mem_we     = 1'b0;
        mem_waddr  = mar;
        wr_data    = data_in;
        rd_en      = 1'b0;
        clr_start  = 1'b0;
        prog_start = 1'b0;
        prog_step  = 1'b0;

        if (ena) begin
            case (state)
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_ptr;
                    wr_data   = '0;
                    if (clr_ptr == LAST_ADDR) begin
                        state_next = IDLE;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state_next = CLEAR;
                        clr_start  = 1'b1;
                    end else if (prog_en) begin
                        state_next = PROG;
                        prog_start = 1'b1;
                    end else if (!lr_n) begin
                        // A write wins over a simultaneous read strobe.
                        mem_we = 1'b1;
                    end else if (!ce_n) begin
                        rd_en = 1'b1;
                    end
                end
                PROG: begin
                    if (!prog_en) begin
                        state_next = IDLE;
                    end else if (prog_wr && !prog_full) begin
                        mem_we    = 1'b1;
                        mem_waddr = prog_addr;
                        prog_step = 1'b1;
                    end
                end
                default: begin
                    state_next = CLEAR;
                end
            endcase
        end
    end

`ifdef DFF_MEM_PARITY_EN
    // The sweep writes zero data, whose even parity is already 0; injection is
    // suppressed there so cleared locations always read back clean.
    logic inj;
    assign inj       = par_inj && (state != CLEAR);
    assign mem_wdata = {(^wr_data) ^ inj, wr_data};
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign mem_wdata      = wr_data;
`endif

    assign rd_word = mem[mar];
    assign busy    = (state == CLEAR);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            state <= CLEAR;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, read data and read strobe
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr   <= '0;
            prog_addr <= '0;
            prog_full <= 1'b0;
            data_out  <= '0;
            rd_valid  <= 1'b0;
        end else begin
            // rd_en is already gated by ena, so a disabled cycle forces 0.
            rd_valid <= rd_en;

            if (rd_en) begin
                data_out <= rd_word[DATA_W-1:0];
            end

            if (clr_start) begin
                clr_ptr <= '0;
            end else if (ena && state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end

            if (prog_start) begin
                prog_addr <= '0;
                prog_full <= 1'b0;
            end else if (prog_step) begin
                // No wrap: the last location latches full and parks the pointer.
                if (prog_addr == LAST_ADDR) begin
                    prog_full <= 1'b1;
                end else begin
                    prog_addr <= prog_addr + 1'b1;
                end
            end
        end
    end

`ifdef DFF_MEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            // XOR over data and stored bit is 1 exactly when they disagree.
            parity_err <= rd_en && (^rd_word);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; the clear sweep that follows every reset
    // zeroes it, which keeps the flops free of reset routing.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dff_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dff_mem_ctrl
//
// Scoreboard bench for dff_mem_ctrl (DATA_W=8, ADDR_W=4). A driver applies one
// input vector per cycle on the falling edge, advances a behavioural model of
// the memory (a plain array plus a sweep countdown and a program cursor) and
// pushes the expected post-edge status and any expected read response into
// queues. A monitor after each rising edge pops and compares.
// -----------------------------------------------------------------------------
module tb_dff_mem_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

`ifdef DFF_MEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic [ADDR_W-1:0] mar = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              ce_n = 1'b1;
    logic              lr_n = 1'b1;
    logic              rd_valid;
    logic              clr_req = 1'b0;
    logic              prog_en = 1'b0;
    logic              prog_wr = 1'b0;
    logic [ADDR_W-1:0] prog_addr;
    logic              prog_full;
    logic              busy;
    logic              par_inj = 1'b0;
    logic              parity_err;

    dff_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mar        (mar),
        .data_in    (data_in),
        .data_out   (data_out),
        .ce_n       (ce_n),
        .lr_n       (lr_n),
        .rd_valid   (rd_valid),
        .clr_req    (clr_req),
        .prog_en    (prog_en),
        .prog_wr    (prog_wr),
        .prog_addr  (prog_addr),
        .prog_full  (prog_full),
        .busy       (busy),
        .par_inj    (par_inj),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              busy;
        logic [ADDR_W-1:0] paddr;
        logic              full;
        logic              rv;
        logic [DATA_W-1:0] dout;
    } status_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              perr;
    } read_t;

    status_t st_q[$];
    read_t   rd_q[$];

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_bad [DEPTH];
    int                m_sweep_left;
    bit                m_prog;
    int                m_paddr;
    bit                m_full;
    logic [DATA_W-1:0] m_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sweep_left = DEPTH;
        m_prog       = 1'b0;
        m_paddr      = 0;
        m_full       = 1'b0;
        m_dout       = '0;
    endtask

    // One cycle: apply inputs on the falling edge and predict the next rising edge.
    task automatic drive(input bit rst, input bit en, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit ce, input bit lr,
                         input bit clr, input bit pe, input bit pw, input bit inj);
        status_t s;
        read_t   r;
        bit      rv;
        @(negedge clk);
        rst_n   = !rst;
        ena     = en;
        mar     = a;
        data_in = d;
        ce_n    = ce;
        lr_n    = lr;
        clr_req = clr;
        prog_en = pe;
        prog_wr = pw;
        par_inj = inj;
        rv      = 1'b0;

        if (rst) begin
            model_reset();
            #1;
            check("rst_busy", busy, 1);
            check("rst_data_out", data_out, 0);
            check("rst_rd_valid", rd_valid, 0);
            check("rst_prog_addr", prog_addr, 0);
            check("rst_prog_full", prog_full, 0);
            check("rst_parity_err", parity_err, 0);
        end else if (en) begin
            if (m_sweep_left > 0) begin
                m_mem[DEPTH - m_sweep_left] = '0;
                m_bad[DEPTH - m_sweep_left] = 1'b0;
                m_sweep_left--;
            end else if (m_prog) begin
                if (!pe) begin
                    m_prog = 1'b0;
                end else if (pw && !m_full) begin
                    m_mem[m_paddr] = d;
                    m_bad[m_paddr] = PAR_EN && inj;
                    if (m_paddr == DEPTH - 1) m_full = 1'b1;
                    else m_paddr++;
                end
            end else if (clr) begin
                m_sweep_left = DEPTH;
            end else if (pe) begin
                m_prog  = 1'b1;
                m_paddr = 0;
                m_full  = 1'b0;
            end else if (!lr) begin
                m_mem[a] = d;
                m_bad[a] = PAR_EN && inj;
            end else if (!ce) begin
                rv     = 1'b1;
                m_dout = m_mem[a];
                r.data = m_mem[a];
                r.perr = m_bad[a];
                rd_q.push_back(r);
            end
        end

        s.busy  = (m_sweep_left > 0);
        s.paddr = ADDR_W'(m_paddr);
        s.full  = m_full;
        s.rv    = rv;
        s.dout  = m_dout;
        st_q.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, '0, '0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit inj);
        drive(0, 1, a, d, 1, 0, 0, 0, 0, inj);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        drive(0, 1, a, '0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i));
    endtask

    // Monitor: pops the expected status every cycle and a read response
    // whenever the DUT presents rd_valid.
    initial begin
        status_t s;
        read_t   r;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("busy", busy, s.busy);
                check("prog_addr", prog_addr, s.paddr);
                check("prog_full", prog_full, s.full);
                check("rd_valid", rd_valid, s.rv);
                check("data_out_hold", data_out, s.dout);
                if (!s.rv) check("parity_err_idle", parity_err, 0);
            end
            if (rd_valid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no read at %0t", $time);
                end else begin
                    r = rd_q.pop_front();
                    check("read_data", data_out, r.data);
                    check("read_parity_err", parity_err, r.perr);
                end
            end
        end
    end

    initial begin
        bit pe_level;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = 1'b0;
        end
        model_reset();

        // Reset, then the power-on sweep and a full read-back of zeros.
        drive(1, 1, '0, '0, 1, 1, 0, 0, 0, 0);
        drive(1, 1, '0, '0, 1, 1, 0, 0, 0, 0);
        // Strobes during the sweep must be ignored.
        drive(0, 1, 4'd2, 8'hEE, 0, 0, 1, 1, 1, 0);
        idle(DEPTH + 1);
        read_all();

        // Write then read next cycle; simultaneous strobes are write-only.
        wr(4'd3, 8'hA5, 0);
        rd(4'd3);
        drive(0, 1, 4'd3, 8'h3C, 0, 0, 0, 0, 0, 0);
        rd(4'd3);
        idle(2);

        // Program load: 17 pulses, last one ignored once full.
        drive(0, 1, '0, '0, 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++)
            drive(0, 1, '0, DATA_W'(8'h10 + i), 0, 0, 1, 1, 1, 0);
        drive(0, 1, '0, '0, 1, 1, 0, 0, 0, 0);
        read_all();

        // Fill, then clr_req together with a write: write dropped, sweep runs.
        for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i), DATA_W'($urandom), 0);
        drive(0, 1, 4'd5, 8'h77, 1, 0, 1, 0, 0, 0);
        idle(DEPTH + 1);
        read_all();

        // Reset at sweep cycle 7.
        drive(1, 1, '0, '0, 1, 1, 0, 0, 0, 0);
        idle(7);
        drive(1, 1, '0, '0, 1, 1, 0, 0, 0, 0);
        idle(DEPTH + 2);

        // ena low for 5 cycles mid-sweep: sweep stalls and resumes.
        drive(0, 1, '0, '0, 1, 1, 1, 0, 0, 0);
        idle(6);
        for (int i = 0; i < 5; i++) drive(0, 0, 4'd1, 8'h99, 0, 0, 1, 1, 1, 1);
        idle(DEPTH);
        read_all();

        // ena low in IDLE: no write, no read strobe.
        drive(0, 0, 4'd9, 8'h42, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 4'd9, 8'h00, 0, 1, 0, 0, 0, 0);
        rd(4'd9);

        // Parity injection on write, then clean rewrite.
        wr(4'd6, 8'h5A, 1);
        rd(4'd6);
        wr(4'd6, 8'h5A, 0);
        rd(4'd6);
        wr(4'd7, 8'h01, 1);
        rd(4'd7);

        // Randomised traffic.
        pe_level = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) pe_level = !pe_level;
            drive($urandom_range(0, 599) == 0,
                  $urandom_range(0, 9) != 0,
                  ADDR_W'($urandom),
                  DATA_W'($urandom),
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 99) == 0,
                  pe_level,
                  pe_level && ($urandom_range(0, 1) == 0),
                  $urandom_range(0, 3) == 0);
        end
        idle(DEPTH + 2);
        read_all();
        idle(2);

        @(posedge clk);
        #2;
        check("read_queue_drained", rd_q.size(), 0);
        check("status_queue_drained", st_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dff_mem_ctrl.md
# dff_mem_ctrl

Parametrised byte-addressable working RAM for the SAP-style datapath. It is the next generation of the 16x8 DFF memory. It keeps the active-low `ce_n` read and `lr_n` load bus interface and adds:
- a self-clearing sweep after reset or on request,
- a registered read-valid strobe,
- an auto-incrementing program-load port for filling memory from the host before the CPU runs.

## Interface
- `DATA_W`, default 8: data word width in bits.
- `ADDR_W`, default 4: address width; depth is `DEPTH = 2**ADDR_W` (derived, not overridable).
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable; when low, all state holds (reset still acts).
- `mar` in `ADDR_W`: bus address for CPU reads/writes.
- `data_in` in `DATA_W`: write data (CPU load and program load).
- `data_out` out `DATA_W`: registered read data.
- `ce_n` in 1: active-low read strobe.
- `lr_n` in 1: active-low write strobe.
- `rd_valid` out 1: one-cycle pulse, `data_out` freshly updated.
- `clr_req` in 1: request a full clear sweep.
- `prog_en` in 1: level; hold high to stay in program-load mode.
- `prog_wr` in 1: program-load write strobe (active high).
- `prog_addr` out `ADDR_W`: next program-load address.
- `prog_full` out 1: last location written in the current program session.
- `busy` out 1: high while the clear sweep runs.
- `par_inj` in 1: invert the stored parity bit on this write (test hook).
- `parity_err` out 1: parity mismatch on the read reported by `rd_valid`.

## Operation
- FSM states: CLEAR, IDLE, PROG.
- **Reset:** state is CLEAR and the clear pointer is 0.
- **Reset output values:** `data_out`=0, `rd_valid`=0, `busy`=1, `prog_addr`=0, `prog_full`=0, `parity_err`=0.
- **CLEAR:**
  - Each enabled cycle writes 0 to location `clr_ptr` and increments the pointer.
  - After writing `DEPTH-1`, the FSM goes to IDLE and `busy` falls.
  - The bus strobes, `clr_req`, `prog_en` and `prog_wr` are ignored. `data_out` holds.
- **IDLE, priority per cycle is `clr_req` > `prog_en` > `lr_n` > `ce_n`:**
  - `clr_req`=1: go to CLEAR with `clr_ptr`=0 and perform no access this cycle.
  - Else `prog_en`=1: go to PROG with `prog_addr`=0 and `prog_full`=0, and perform no access.
  - Else `lr_n`=0: `mem[mar] <= data_in`.
  - Else `ce_n`=0: `data_out <= mem[mar]` and `rd_valid` pulses.
  - Simultaneous `lr_n`=0 and `ce_n`=0 is a write only, with no read and no `rd_valid`.
- **PROG:**
  - `prog_wr`=1 with `prog_full`=0: `mem[prog_addr] <= data_in`.
    - If `prog_addr` is `DEPTH-1`, set `prog_full` and hold `prog_addr`.
    - Otherwise `prog_addr` increments.
  - `prog_wr` while `prog_full`=1 is ignored; there is no wrap-around.
  - `ce_n`, `lr_n` and `clr_req` are ignored.
  - `prog_en`=0: return to IDLE. `prog_full` and `prog_addr` hold until the next PROG entry.
- **`ena`=0:** no memory writes, no state, pointer or output change, and `rd_valid` is forced 0 that cycle.
- **Reset mid-sweep or mid-program:** the operation aborts immediately and the sweep restarts from 0 after `rst_n` rises. Memory contents already written are overwritten by the sweep.

## Timing
- The clear sweep takes exactly `DEPTH` enabled cycles.
  - After a reset release, `busy` is 1 for the first `DEPTH` rising edges with `ena`=1, then 0.
  - For `clr_req`, `busy` rises the cycle after `clr_req` is sampled.
- Read latency is 1: `ce_n` is sampled low at edge N, and `data_out`/`rd_valid`/`parity_err` are valid after edge N. `rd_valid` drops after edge N+1 unless another read occurs.
- Write-then-read of the same address on consecutive cycles returns the new data.
- No combinational path from any input to any output.

## Configuration
- `DFF_MEM_PARITY_EN` defined:
  - Each location stores `DATA_W+1` bits: data plus even parity of the data.
  - The stored parity bit is inverted when `par_inj`=1 on that write. This applies to CPU writes and program writes; the clear sweep stores parity 0.
  - On each read, `parity_err` is registered as the recomputed parity XOR the stored parity, with the same timing as `rd_valid`.
  - `parity_err` is 0 on cycles without `rd_valid`.
- `DFF_MEM_PARITY_EN` undefined:
  - Storage is `DATA_W` bits per location.
  - `par_inj` is ignored and `parity_err` is constant 0.

## Test plan
- Release reset with `ena`=1 (defaults) -> `busy`=1 for 16 cycles then 0; reading all addresses returns 0x00 with `rd_valid` one cycle after each `ce_n` low.
- In IDLE, write 0xA5 to 3, then `ce_n`=0 `mar`=3 next cycle -> `data_out`=0xA5 and `rd_valid`=1 one cycle later; `lr_n`=`ce_n`=0 together -> no `rd_valid`.
- `prog_en`=1 followed by 17 `prog_wr` pulses with data 0x10..0x20 -> locations 0..15 hold 0x10..0x1F; `prog_full`=1 after the 16th pulse and the 17th is ignored; `prog_addr` stays 15.
- Fill memory, assert `clr_req` with `lr_n`=0 -> that write is dropped, `busy` is high 16 cycles, and all locations read 0x00.
- Pulse `rst_n` low at sweep cycle 7, or drop `ena` for 5 cycles mid-sweep -> sweep restarts at 0, or stalls and resumes; total `busy` length matches.
- With `DFF_MEM_PARITY_EN`: write 0x5A with `par_inj`=1, then read -> `parity_err`=1 with `rd_valid`; rewrite with `par_inj`=0 -> `parity_err`=0.
